// File: rtl/uart_receiver_pkg.sv
// -----------------------------------------------------------------------------
// uart_receiver_pkg
//
// Shared UART definitions used by the transmitter and the receiver:
//   - frame constants (16x oversampling, mid-bit tick, data width)
//   - receiver FSM state encodings
//   - baud-rate codes and the divisor table that turns a baud_select code
//     into the number of system clocks per 16x sample tick
//
// The divisor table assumes a 1.8432 MHz system clock, which divides evenly
// into every supported rate at 16x oversampling.
// -----------------------------------------------------------------------------
package uart_receiver_pkg;

   // Frame geometry
   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int TICK_WIDTH = 4;

   // Tick-counter values: the middle of the start bit and the last tick of a
   // 16-tick bit period (which, once aligned to mid-start, is mid-bit).
   localparam logic [TICK_WIDTH-1:0] MID_BIT_TICK   = TICK_WIDTH'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_WIDTH-1:0] LAST_TICK      = TICK_WIDTH'(OVERSAMPLE - 1);
   localparam logic [2:0]            LAST_BIT_INDEX = 3'(DATA_BITS - 1);

   // Width of the baud divisor counter
   localparam int DIV_WIDTH = 8;

   // Receiver FSM encodings; codes 6 and 7 are unused and recover to OFF
   typedef logic [2:0] uart_state_t;
   localparam uart_state_t ST_OFF    = 3'd0;
   localparam uart_state_t ST_IDLE   = 3'd1;
   localparam uart_state_t ST_START  = 3'd2;
   localparam uart_state_t ST_DATA   = 3'd3;
   localparam uart_state_t ST_PARITY = 3'd4;
   localparam uart_state_t ST_STOP   = 3'd5;

   // Baud-rate codes shared with the transmitter
   typedef enum logic [2:0] {
      BAUD_115200 = 3'd0,
      BAUD_57600  = 3'd1,
      BAUD_38400  = 3'd2,
      BAUD_28800  = 3'd3,
      BAUD_19200  = 3'd4,
      BAUD_14400  = 3'd5,
      BAUD_9600   = 3'd6,
      BAUD_7200   = 3'd7
   } baud_code_t;

   // System clocks per 16x sample tick for each baud code
   function automatic logic [DIV_WIDTH-1:0] baud_divisor(input logic [2:0] code);
      logic [DIV_WIDTH-1:0] div;
      case (baud_code_t'(code))
         BAUD_115200: div = 8'd1;
         BAUD_57600:  div = 8'd2;
         BAUD_38400:  div = 8'd3;
         BAUD_28800:  div = 8'd4;
         BAUD_19200:  div = 8'd6;
         BAUD_14400:  div = 8'd8;
         BAUD_9600:   div = 8'd12;
         BAUD_7200:   div = 8'd16;
         default:     div = 8'd16;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/uart_receiver_baud_controller.sv
// -----------------------------------------------------------------------------
// Baud_controller
//
// Generates the 16x-baud sample tick for the UART receiver. A free-running
// counter divides the system clock by the divisor selected by baud_select and
// emits a one-clock sample_ENABLE pulse each time it wraps.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active high
//   baud_select   in   baud-rate code (see uart_receiver_pkg)
//   sample_ENABLE out  one-clock pulse at 16x the selected baud rate
// -----------------------------------------------------------------------------
module Baud_controller
   import uart_receiver_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   output logic       sample_ENABLE
);

   logic [DIV_WIDTH-1:0] div_count;
   logic [DIV_WIDTH-1:0] div_last;

   // Terminal count for the selected rate. Comparing with >= rather than ==
   // lets the counter recover at once if baud_select shrinks the divisor
   // while the count is already beyond the new terminal value.
   assign div_last = baud_divisor(baud_select) - DIV_WIDTH'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_count     <= '0;
         sample_ENABLE <= 1'b0;
      end else if (div_count >= div_last) begin
         div_count     <= '0;
         sample_ENABLE <= 1'b1;
      end else begin
         div_count     <= div_count + DIV_WIDTH'(1);
         sample_ENABLE <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// 8E1 UART receiver with 16x oversampling. The serial line is synchronized,
// a falling edge in IDLE starts a frame, the start bit is re-checked at its
// middle and every following bit is sampled 16 ticks later. Good bytes are
// published on Rx_DATA with a one-clock Rx_VALID pulse; frames with a parity
// or stop-bit error leave Rx_DATA alone and raise sticky error flags instead.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active low (0 = reset)
//   baud_select in   baud-rate code, same encoding as the transmitter
//   Rx_EN       in   receiver enable; 0 forces the FSM to OFF
//   RxD         in   asynchronous serial line, idle high
//   Rx_DATA     out  last correctly received byte
//   Rx_VALID    out  one-clock pulse when a new good byte is on Rx_DATA
//   Rx_PERROR   out  sticky parity error of the last frame
//   Rx_FERROR   out  sticky framing (stop-bit) error of the last frame
//
// Parameter:
//   SYNC_STAGES number of synchronizer flops on RxD (values below 2 use 2)
// -----------------------------------------------------------------------------
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR
);

   localparam int SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic                  baud_reset;
   logic                  sample_ENABLE;
   logic [SYNC_DEPTH-1:0] sync_ff;
   logic                  rx_line;
   logic                  rx_prev;
   logic                  start_edge;
   logic                  mid_start_tick;
   logic                  bit_tick;
   uart_state_t           state;
   logic [TICK_WIDTH-1:0] tick_count;
   logic [2:0]            bit_index;
   logic [DATA_BITS-1:0]  shift_reg;
   logic                  parity_fail;

   // The baud controller uses an active-high reset
   assign baud_reset = ~reset;

   Baud_controller u_baud (
      .clk           (clk),
      .reset         (baud_reset),
      .baud_select   (baud_select),
      .sample_ENABLE (sample_ENABLE)
   );

   // Synchronizer chain on RxD. Flops preset to 1 so that leaving reset
   // never looks like a falling edge on an idle line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_ff <= '1;
      end else begin
         sync_ff <= {sync_ff[SYNC_DEPTH-2:0], RxD};
      end
   end

   assign rx_line = sync_ff[SYNC_DEPTH-1];

   // One more flop on the synchronized line for 1->0 edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_prev <= 1'b1;
      end else begin
         rx_prev <= rx_line;
      end
   end

   assign start_edge     = rx_prev & ~rx_line;
   assign mid_start_tick = sample_ENABLE && (tick_count == MID_BIT_TICK);
   assign bit_tick       = sample_ENABLE && (tick_count == LAST_TICK);

   // Receiver FSM and datapath.
   // Dropping Rx_EN wins over every state and clears the sticky flags; the
   // frame in progress is discarded without touching Rx_DATA or Rx_VALID.
   // The start bit is confirmed at its middle; that moment is both where the
   // tick counter is realigned and where the previous frame's error flags
   // are cleared. From then on tick_count wraps naturally every 16 ticks and
   // each wrap lands in the middle of the next bit. The STOP sample returns
   // to IDLE immediately so a start edge in the second half of the stop bit
   // is caught.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_OFF;
         tick_count  <= '0;
         bit_index   <= '0;
         shift_reg   <= '0;
         parity_fail <= 1'b0;
         Rx_DATA     <= 8'h00;
         Rx_VALID    <= 1'b0;
         Rx_PERROR   <= 1'b0;
         Rx_FERROR   <= 1'b0;
      end else begin
         Rx_VALID <= 1'b0;
         if (!Rx_EN) begin
            state       <= ST_OFF;
            tick_count  <= '0;
            bit_index   <= '0;
            parity_fail <= 1'b0;
            Rx_PERROR   <= 1'b0;
            Rx_FERROR   <= 1'b0;
         end else begin
            case (state)
               ST_OFF: begin
                  state <= ST_IDLE;
               end

               ST_IDLE: begin
                  if (start_edge) begin
                     state      <= ST_START;
                     tick_count <= '0;
                  end
               end

               ST_START: begin
                  if (mid_start_tick) begin
                     if (!rx_line) begin
                        state       <= ST_DATA;
                        tick_count  <= '0;
                        bit_index   <= '0;
                        parity_fail <= 1'b0;
                        Rx_PERROR   <= 1'b0;
                        Rx_FERROR   <= 1'b0;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else if (sample_ENABLE) begin
                     tick_count <= tick_count + TICK_WIDTH'(1);
                  end
               end

               ST_DATA: begin
                  if (sample_ENABLE) begin
                     tick_count <= tick_count + TICK_WIDTH'(1);
                  end
                  if (bit_tick) begin
                     shift_reg <= {rx_line, shift_reg[DATA_BITS-1:1]};
                     bit_index <= bit_index + 3'd1;
                     if (bit_index == LAST_BIT_INDEX) begin
                        state <= ST_PARITY;
                     end
                  end
               end

               ST_PARITY: begin
                  if (sample_ENABLE) begin
                     tick_count <= tick_count + TICK_WIDTH'(1);
                  end
                  if (bit_tick) begin
                     parity_fail <= rx_line ^ (^shift_reg);
                     state       <= ST_STOP;
                  end
               end

               ST_STOP: begin
                  if (sample_ENABLE) begin
                     tick_count <= tick_count + TICK_WIDTH'(1);
                  end
                  if (bit_tick) begin
                     state <= ST_IDLE;
                     if (rx_line && !parity_fail) begin
                        Rx_DATA  <= shift_reg;
                        Rx_VALID <= 1'b1;
                     end else begin
                        Rx_PERROR <= parity_fail;
                        Rx_FERROR <= ~rx_line;
                     end
                  end
               end

               default: begin
                  state <= ST_OFF;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Self-checking bench for uart_receiver. A bench-side serial driver plays the
// role of the transmitter; a small frame model predicts Rx_DATA, Rx_VALID
// pulses and the sticky error flags from the frame contents alone.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] baud_select;
   logic       Rx_EN;
   logic       RxD;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID;
   logic       Rx_PERROR;
   logic       Rx_FERROR;

   int assertCount = 0;
   int failCount   = 0;

   // Clocks per 16x tick for each baud code at 1.8432 MHz
   int divTable[8] = '{1, 2, 3, 4, 6, 8, 12, 16};

   // Every Rx_VALID high cycle is logged with the data seen alongside it
   int         validCount = 0;
   logic [7:0] validLog[$];

   // Reference model state
   logic [7:0] modelData;
   logic       modelPerr;
   logic       modelFerr;

   typedef struct {
      logic [7:0] data;
      logic       parityBit;
      logic       stopBit;
      int         expValid;
      logic [7:0] expData;
      logic       expPerr;
      logic       expFerr;
   } frameVec_t;

   frameVec_t vecs[5];

   uart_receiver #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .Rx_EN       (Rx_EN),
      .RxD         (RxD),
      .Rx_DATA     (Rx_DATA),
      .Rx_VALID    (Rx_VALID),
      .Rx_PERROR   (Rx_PERROR),
      .Rx_FERROR   (Rx_FERROR)
   );

   always #5 clk = ~clk;

   // Outputs are sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (Rx_VALID === 1'b1) begin
         validCount++;
         validLog.push_back(Rx_DATA);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic evenParity(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) begin
         if (d[i]) ones++;
      end
      return logic'(ones % 2);
   endfunction

   // Serializes one frame: start, 8 data bits LSB first, parity, stop
   task automatic sendFrame(input logic [7:0] data, input logic parityBit,
                            input logic stopBit);
      int         div;
      logic [10:0] bits;
      div  = divTable[baud_select];
      bits = {stopBit, parityBit, data, 1'b0};
      for (int i = 0; i < 11; i++) begin
         RxD = bits[i];
         repeat (16 * div) @(negedge clk);
      end
      RxD = 1'b1;
   endtask

   task automatic idleBits(input int n);
      RxD = 1'b1;
      repeat (16 * divTable[baud_select] * n) @(negedge clk);
   endtask

   // Sends one frame and checks the outcome against the frame model
   task automatic applyStimulus(input string tag, input logic [7:0] data,
                                input logic parityBit, input logic stopBit);
      int   v0;
      logic good;
      v0   = validCount;
      sendFrame(data, parityBit, stopBit);
      idleBits(2);
      good = (parityBit == evenParity(data)) && stopBit;
      if (good) begin
         modelData = data;
         modelPerr = 1'b0;
         modelFerr = 1'b0;
      end else begin
         modelPerr = (parityBit != evenParity(data));
         modelFerr = ~stopBit;
      end
      checkOutput({tag, " valid pulses"}, validCount - v0, good ? 1 : 0);
      checkOutput({tag, " Rx_DATA"}, Rx_DATA, modelData);
      checkOutput({tag, " Rx_PERROR"}, Rx_PERROR, modelPerr);
      checkOutput({tag, " Rx_FERROR"}, Rx_FERROR, modelFerr);
   endtask

   initial begin
      int v0;
      int q0;
      logic [7:0] loopData[3];

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 0, 8'hA5, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 8'hA5, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 1'b1, 1'b0, 0, 8'hA5, 1'b1, 1'b1};
      vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b0};
      loopData[0] = 8'h00;
      loopData[1] = 8'hFF;
      loopData[2] = 8'h55;

      reset       = 1'b0;
      Rx_EN       = 1'b0;
      RxD         = 1'b1;
      baud_select = 3'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset Rx_DATA", Rx_DATA, 8'h00);
      checkOutput("reset Rx_VALID", Rx_VALID, 1'b0);
      checkOutput("reset Rx_PERROR", Rx_PERROR, 1'b0);
      checkOutput("reset Rx_FERROR", Rx_FERROR, 1'b0);
      reset = 1'b1;
      Rx_EN = 1'b1;
      idleBits(2);

      // Directed frame table
      for (int i = 0; i < 5; i++) begin
         v0 = validCount;
         sendFrame(vecs[i].data, vecs[i].parityBit, vecs[i].stopBit);
         idleBits(2);
         checkOutput($sformatf("vec%0d valid pulses", i), validCount - v0, vecs[i].expValid);
         checkOutput($sformatf("vec%0d Rx_DATA", i), Rx_DATA, vecs[i].expData);
         checkOutput($sformatf("vec%0d Rx_PERROR", i), Rx_PERROR, vecs[i].expPerr);
         checkOutput($sformatf("vec%0d Rx_FERROR", i), Rx_FERROR, vecs[i].expFerr);
      end

      // Framing error, then a short glitch that must be rejected
      sendFrame(8'h3C, 1'b0, 1'b0);
      idleBits(2);
      checkOutput("ferr frame Rx_FERROR", Rx_FERROR, 1'b1);
      v0  = validCount;
      RxD = 1'b0;
      repeat (4 * divTable[baud_select]) @(negedge clk);
      RxD = 1'b1;
      idleBits(2);
      checkOutput("glitch valid pulses", validCount - v0, 0);
      checkOutput("glitch Rx_DATA", Rx_DATA, 8'h00);
      checkOutput("glitch Rx_FERROR kept", Rx_FERROR, 1'b1);
      checkOutput("glitch Rx_PERROR", Rx_PERROR, 1'b0);

      // Good frame clears the sticky error at its start bit
      v0 = validCount;
      fork
         sendFrame(8'h3C, 1'b0, 1'b1);
         begin
            repeat (2 * divTable[baud_select]) @(negedge clk);
            checkOutput("ferr before start sample", Rx_FERROR, 1'b1);
            repeat (22 * divTable[baud_select]) @(negedge clk);
            checkOutput("ferr cleared at start", Rx_FERROR, 1'b0);
         end
      join
      idleBits(2);
      checkOutput("recovery valid pulses", validCount - v0, 1);
      checkOutput("recovery Rx_DATA", Rx_DATA, 8'h3C);

      // Receiver disabled during data bit 3
      v0 = validCount;
      fork
         sendFrame(8'hC3, 1'b0, 1'b1);
         begin
            repeat ((16 + 16 * 3 + 8) * divTable[baud_select]) @(negedge clk);
            Rx_EN = 1'b0;
         end
      join
      idleBits(1);
      checkOutput("abort valid pulses", validCount - v0, 0);
      checkOutput("abort Rx_DATA", Rx_DATA, 8'h3C);
      Rx_EN = 1'b1;
      idleBits(1);

      // Parity error after re-enable, then reset in the middle of a frame
      modelData = 8'h3C;
      applyStimulus("post-abort parity", 8'h01, 1'b0, 1'b1);
      v0 = validCount;
      fork
         sendFrame(8'h55, 1'b0, 1'b1);
         begin
            repeat (40 * divTable[baud_select]) @(negedge clk);
            #1 reset = 1'b0;
            #1;
            checkOutput("async reset Rx_DATA", Rx_DATA, 8'h00);
            checkOutput("async reset Rx_VALID", Rx_VALID, 1'b0);
            checkOutput("async reset Rx_PERROR", Rx_PERROR, 1'b0);
            checkOutput("async reset Rx_FERROR", Rx_FERROR, 1'b0);
         end
      join
      repeat (4) @(negedge clk);
      reset = 1'b1;
      idleBits(1);
      checkOutput("reset frame discarded", validCount - v0, 0);
      modelData = 8'h00;
      modelPerr = 1'b0;
      modelFerr = 1'b0;

      // Randomized frames against the frame model
      for (int n = 0; n < 20; n++) begin
         logic [7:0] d;
         logic       corrupt;
         logic       stopBit;
         baud_select = 3'($urandom_range(0, 3));
         idleBits(1);
         d       = 8'($urandom);
         corrupt = ($urandom_range(0, 3) == 0);
         stopBit = ($urandom_range(0, 3) != 0);
         applyStimulus($sformatf("rand%0d", n), d, evenParity(d) ^ corrupt, stopBit);
      end

      // Back-to-back loopback frames at every baud rate
      for (int s = 0; s < 8; s++) begin
         baud_select = 3'(s);
         idleBits(2);
         v0 = validCount;
         q0 = validLog.size();
         for (int k = 0; k < 3; k++) begin
            sendFrame(loopData[k], evenParity(loopData[k]), 1'b1);
         end
         idleBits(2);
         checkOutput($sformatf("loop sel%0d pulses", s), validCount - v0, 3);
         for (int k = 0; k < 3; k++) begin
            if (validLog.size() > q0 + k) begin
               checkOutput($sformatf("loop sel%0d byte%0d", s, k), validLog[q0 + k], loopData[k]);
            end else begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL loop sel%0d byte%0d: actual=missing expected=0x%0h",
                        s, k, loopData[k]);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flip-flops in the RxD synchronizer (minimum 2).
REQ-002 Port: clk, input, 1, single system clock; all logic on rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 Port: baud_select, input, 3, baud-rate code, same encoding as the transmitter's.
REQ-005 Port: Rx_EN, input, 1, receiver enable; 0 forces OFF.
REQ-006 Port: RxD, input, 1, asynchronous serial line; idle high.
REQ-007 Port: Rx_DATA, output, 8, last correctly received byte.
REQ-008 Port: Rx_VALID, output, 1, one-clk pulse when a new error-free byte is on Rx_DATA.
REQ-009 Port: Rx_PERROR, output, 1, sticky parity error of the last frame.
REQ-010 Port: Rx_FERROR, output, 1, sticky framing (stop-bit) error of the last frame.

Function
REQ-011 Frame format SHALL be: start (0), 8 data bits LSB first, even parity bit (= XOR of the 8 data bits), stop (1).
REQ-012 RxD SHALL pass through SYNC_STAGES flip-flops before use; all rules below refer to the synchronized line.
REQ-013 A 16x-baud tick (sample_ENABLE) SHALL drive a 4-bit tick counter; the counter advances only on ticks.
REQ-014 FSM states SHALL be OFF, IDLE, START, DATA, PARITY, STOP.
REQ-015 OFF -> IDLE when Rx_EN=1; any state -> OFF on the clock after Rx_EN=0; an aborted frame produces no Rx_VALID and no error update.
REQ-016 IDLE -> START on a synchronized 1->0 transition; the tick counter SHALL clear on entry.
REQ-017 START: at tick count 7 (mid-bit) the line SHALL be re-sampled; 0 -> DATA with counter cleared, 1 -> IDLE (glitch rejected, no output change).
REQ-018 DATA: every 16 ticks (count 15, wrapping) one bit SHALL be shifted into the shift register LSB first; a 3-bit index counter SHALL move to PARITY after bit 7.
REQ-019 PARITY: mid-bit sample compared against the XOR of the shift register; mismatch sets an internal parity-fail flag.
REQ-020 STOP: mid-bit sample; 0 = framing fail. On this sample the FSM SHALL return to IDLE, so a start edge in the second half of the stop bit is accepted.
REQ-021 At the stop sample: no fail -> Rx_DATA <= shift register and Rx_VALID = 1 for exactly one clk; parity/framing fail -> Rx_DATA unchanged, Rx_VALID stays 0, Rx_PERROR/Rx_FERROR <= respective fail flags (both may be set).
REQ-022 Rx_PERROR and Rx_FERROR SHALL hold until the next accepted start bit (REQ-017) clears them, or until OFF is entered.
REQ-023 Latency: Rx_VALID SHALL assert at most 2 clks after the stop-bit mid-sample tick.
REQ-024 Unused FSM encodings SHALL recover to OFF on the next clock.

Reset
REQ-025 reset=0 SHALL immediately (asynchronously) set the FSM to OFF, clear counters and the shift register, drive Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, and preset synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL discard the frame; after release, reception resumes only via OFF -> IDLE -> a new start edge.

Structure
REQ-027 State encodings, frame constants (16x oversample, mid-bit count 7, 8 data bits) and the baud divisor table SHALL live in the shared UART defines package used by transmitter and receiver.
REQ-028 One sub-module: a Baud_controller instance generating sample_ENABLE, driven with the inverted (active-high) reset.

Verification
REQ-029 Rx_EN=1, frame 0xA5 with parity 0, stop 1 -> Rx_DATA=8'hA5, one Rx_VALID pulse, Rx_PERROR=Rx_FERROR=0.
REQ-030 Frame 0x01 sent with parity bit 0 -> Rx_PERROR=1, Rx_VALID never asserts, Rx_DATA keeps its previous value.
REQ-031 Frame 0x3C with stop bit 0 -> Rx_FERROR=1, no Rx_VALID; next good frame 0x3C clears the error at its start bit and gives Rx_VALID.
REQ-032 RxD low pulse of 4 ticks in IDLE -> FSM returns to IDLE, no output change; Rx_EN=0 at data bit 3 -> OFF, no Rx_VALID.
REQ-033 reset=0 mid-frame -> all outputs 0 within the same cycle; back-to-back loopback from uart_transmitter (0x00, 0xFF, 0x55) at every baud_select value -> three Rx_VALID pulses with matching data.
